// File: rtl/tinytpu_pkg.sv
// Shared types and default widths for the tinytpu output stage.
// Optional build macro: TINYTPU_SER_PARITY_EN appends an even-parity bit to every word.
package tinytpu_pkg;

    localparam int D_W   = 8;
    localparam int N     = 2;
    localparam int ACC_W = 2 * D_W;

`ifdef TINYTPU_SER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Serial bits in one frame, parity bits included.
    function automatic int FRAME_BITS(input int n, input int acc_w, input bit parity);
        return n * n * (acc_w + (parity ? 1 : 0));
    endfunction

endpackage

// File: rtl/tpu_frame_counter.sv
// Bit/word position tracker for one serial frame.
// Bits run 0..WORD_LEN-1 within each word, and words run 0..NUM_WORDS-1.
module tpu_frame_counter import tinytpu_pkg::*; #(
    parameter int ACC_W     = tinytpu_pkg::ACC_W,
    parameter int WORD_LEN  = tinytpu_pkg::ACC_W,
    parameter int NUM_WORDS = 4,
    localparam int BCW = $clog2(ACC_W + 1),
    localparam int WCW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           advance,
    output logic [BCW-1:0] bit_cnt,
    output logic [WCW-1:0] word_cnt,
    output logic           last_bit_of_word,
    output logic           last_bit_of_frame
);

    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;

    assign last_bit_of_word  = (bit_cnt_q == BCW'(WORD_LEN - 1));
    assign last_bit_of_frame = last_bit_of_word && (word_cnt_q == WCW'(NUM_WORDS - 1));
    assign bit_cnt  = bit_cnt_q;
    assign word_cnt = word_cnt_q;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        if (clear) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
        end else if (advance) begin
            if (last_bit_of_word) begin
                bit_cnt_d  = '0;
                word_cnt_d = last_bit_of_frame ? '0 : word_cnt_q + 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

endmodule

// File: rtl/tpu_result_serializer.sv
// Captures an N*N accumulator matrix in one handshake and streams it MSB-first on data_out_z.
// Optional build macro: TINYTPU_SER_PARITY_EN sends an even-parity bit after each word's LSB.
module tpu_result_serializer import tinytpu_pkg::*; #(
    parameter int D_W   = tinytpu_pkg::D_W,
    parameter int N     = tinytpu_pkg::N,
    parameter int ACC_W = 2 * D_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 res_valid,
    input  logic [N*N*ACC_W-1:0] res_data,
    output logic                 res_ready,
    input  logic                 tx_pause,
    output logic                 data_out_z,
    output logic                 tx_ready,
    output logic                 busy
);

    localparam int NW       = N * N;
    localparam int WORD_LEN = ACC_W + (PARITY_EN ? 1 : 0);
    localparam int BCW      = $clog2(ACC_W + 1);
    localparam int WCW      = (NW > 1) ? $clog2(NW) : 1;

    ser_state_e                 state_q, state_d;
    logic                       res_ready_q, res_ready_d;
    logic                       tx_ready_q, tx_ready_d;
    logic                       dout_q, dout_d;
    logic                       busy_q, busy_d;
    logic [NW-1:0][ACC_W-1:0]   frame_q, frame_d;

    logic           capture, advance;
    logic [BCW-1:0] bit_cnt, nxt_bit;
    logic [WCW-1:0] word_cnt, nxt_word;
    logic           last_bit_of_word, last_bit_of_frame;
    logic           nxt_val;

    tpu_frame_counter #(
        .ACC_W     (ACC_W),
        .WORD_LEN  (WORD_LEN),
        .NUM_WORDS (NW)
    ) u_cnt (
        .clk               (clk),
        .rst_n             (rst_n),
        .clear             (capture),
        .advance           (advance),
        .bit_cnt           (bit_cnt),
        .word_cnt          (word_cnt),
        .last_bit_of_word  (last_bit_of_word),
        .last_bit_of_frame (last_bit_of_frame)
    );

    // The bit that follows the one currently on the pin; only used when not at end of frame.
    always_comb begin
        nxt_bit  = last_bit_of_word ? '0 : bit_cnt + 1'b1;
        nxt_word = last_bit_of_word ? word_cnt + 1'b1 : word_cnt;
        nxt_val  = 1'b0;
        for (int k = 0; k < NW; k++) begin
            if (nxt_word == WCW'(k)) begin
                for (int b = 0; b < ACC_W; b++) begin
                    if (nxt_bit == BCW'(ACC_W - 1 - b)) nxt_val = frame_q[k][b];
                end
`ifdef TINYTPU_SER_PARITY_EN
                if (nxt_bit == BCW'(ACC_W)) nxt_val = ^frame_q[k];
`endif
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        res_ready_d = res_ready_q;
        tx_ready_d  = tx_ready_q;
        dout_d      = dout_q;
        frame_d     = frame_q;
        capture     = 1'b0;
        advance     = 1'b0;
        case (state_q)
            IDLE: begin
                res_ready_d = 1'b1;
                if (res_valid && res_ready_q) begin
                    capture     = 1'b1;
                    frame_d     = res_data;
                    state_d     = SHIFT;
                    res_ready_d = 1'b0;
                    tx_ready_d  = 1'b1;
                    dout_d      = res_data[ACC_W-1];
                end
            end
            SHIFT: begin
                if (!tx_pause) begin
                    advance = 1'b1;
                    if (last_bit_of_frame) begin
                        state_d     = IDLE;
                        res_ready_d = 1'b1;
                        tx_ready_d  = 1'b0;
                        dout_d      = 1'b0;
                    end else begin
                        dout_d = nxt_val;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            res_ready_q <= 1'b0;
            tx_ready_q  <= 1'b0;
            dout_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_ready_q <= res_ready_d;
            tx_ready_q  <= tx_ready_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
        end
    end

    // Frame contents are don't-care until a capture, so no reset is needed.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign res_ready  = res_ready_q;
    assign tx_ready   = tx_ready_q;
    assign data_out_z = dout_q;
    assign busy       = busy_q;

endmodule
